// File: rtl/bit_adder_pkg.sv
// Shared ALU definitions used by the bit_adder carry-chain cell and its clocked wrapper.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic {
    CIN_EXT      = 1'b0,
    CIN_FEEDBACK = 1'b1
  } cin_sel_e;

  function automatic cin_sel_e cin_select(input logic serial_mode, input logic start);
    return (serial_mode && !start) ? CIN_FEEDBACK : CIN_EXT;
  endfunction

endpackage

// File: rtl/bit_adder_if.sv
// Operand/result bundle for bit_adder; master drives operands, slave produces results.
interface bit_adder_if #(
  parameter int unsigned CNT_W = 5
);
  logic             OPA;
  logic             OPB;
  logic             carryIn;
  logic             en;
  logic             serial_mode;
  logic             start;
  logic             result;
  logic             carryOut;
  logic             result_q;
  logic             carry_q;
  logic             valid_q;
  logic [CNT_W-1:0] bit_count;
  logic             last_q;

  modport master (
    output OPA, OPB, carryIn, en, serial_mode, start,
    input  result, carryOut, result_q, carry_q, valid_q, bit_count, last_q
  );

  modport slave (
    input  OPA, OPB, carryIn, en, serial_mode, start,
    output result, carryOut, result_q, carry_q, valid_q, bit_count, last_q
  );
endinterface

// File: rtl/bit_adder_full_adder_cell.sv
// Pure combinational one-bit full adder: the ALU carry-chain cell.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);
  logic prop;

  always_comb begin
    prop    = a_i ^ b_i;
    sum_o   = prop ^ c_i;
    carry_o = (a_i & b_i) | (c_i & prop);
  end
endmodule

// File: rtl/bit_adder.sv
// Full-adder cell with a registered result and LSB-first bit-serial accumulation
// that feeds the stored carry back into the cell.
module bit_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  bit_adder_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic             cin_eff;
  logic             sum;
  logic             cout;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             last_d;
  logic             sum_q, cout_q, valid_q, last_q;

  // Carry source depends only on inputs and carry_q, so non-serial use never needs clk/rst.
  always_comb begin
    cin_eff = (cin_select(bus.serial_mode, bus.start) == CIN_FEEDBACK) ? cout_q : bus.carryIn;
  end

  full_adder_cell u_cell (
    .a_i     (bus.OPA),
    .b_i     (bus.OPB),
    .c_i     (cin_eff),
    .sum_o   (sum),
    .carry_o (cout)
  );

  // cnt_d is the index of the bit being registered on this edge.
  always_comb begin
    cnt_d = '0;
    if (!(bus.start || !bus.serial_mode)) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
    end
    last_d = bus.serial_mode && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.en) begin
      sum_q   <= sum;
      cout_q  <= cout;
      valid_q <= 1'b1;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign bus.result    = sum;
  assign bus.carryOut  = cout;
  assign bus.result_q  = sum_q;
  assign bus.carry_q   = cout_q;
  assign bus.valid_q   = valid_q;
  assign bus.bit_count = cnt_q;
  assign bus.last_q    = last_q;
endmodule

// File: tb/tb_bit_adder.sv
// Directed self-checking bench for bit_adder with a 4-bit serial width.
module tb_bit_adder;
  import alu_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic clk;
  logic rst;
  logic clk_run = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  bit_adder_if #(.CNT_W(CW)) bus ();

  bit_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  // Packed view of the registered outputs: {result_q, carry_q, valid_q, last_q, bit_count}
  function automatic logic [5:0] regs();
    return {bus.result_q, bus.carry_q, bus.valid_q, bus.last_q, bus.bit_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input logic c,
                       input logic e, input logic sm, input logic st);
    bus.OPA = a; bus.OPB = b; bus.carryIn = c;
    bus.en = e; bus.serial_mode = sm; bus.start = st;
  endtask

  task automatic test_comb();
    logic [2:0] v;
    logic [1:0] exp;
    for (int unsigned i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0);
      #1;
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      n_total++;
      if ({bus.carryOut, bus.result} !== exp)
        $display("FAIL comb %0d+%0d+%0d: got {carryOut,result}=%b want %b",
                 v[2], v[1], v[0], {bus.carryOut, bus.result}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 1, 1, 0, 0);
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if (regs() !== 6'b0000_00)
      $display("FAIL async_reset: got regs=%b want %b", regs(), 6'b0);
    else n_pass++;
    tick();
    n_total++;
    if (regs() !== 6'b0)
      $display("FAIL reset_hold: got regs=%b want %b", regs(), 6'b0);
    else n_pass++;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_registered();
    drive(1, 1, 1, 1, 0, 0);
    tick();
    n_total++;
    if (regs() !== 6'b1110_00)
      $display("FAIL reg_capture: got regs=%b want %b", regs(), 6'b111000);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_total++;
    if (regs() !== 6'b1100_00)
      $display("FAIL reg_hold: got regs=%b want %b", regs(), 6'b110000);
    else n_pass++;
  endtask

  // Operands and expected per-bit {result_q, carry_q, valid_q, last_q, bit_count}
  task automatic run_serial(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [5:0] exp [4]);
    for (int unsigned k = 0; k < W; k++) begin
      drive(a[k], b[k], 1'b0, 1'b1, 1'b1, (k == 0));
      tick();
      n_total++;
      if (regs() !== exp[k])
        $display("FAIL %s bit%0d: got regs=%b want %b", name, k, regs(), exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_serial_add();
    logic [5:0] exp [4];
    exp = '{6'b0_1_1_0_00, 6'b0_1_1_0_01, 6'b0_1_1_0_10, 6'b1_0_1_1_11};
    run_serial("serial_add", 4'b0111, 4'b0001, exp);
  endtask

  task automatic test_serial_overflow();
    logic [5:0] exp [4];
    exp = '{6'b0_1_1_0_00, 6'b0_1_1_0_01, 6'b0_1_1_0_10, 6'b0_1_1_1_11};
    run_serial("serial_ovf", 4'b1111, 4'b0001, exp);
    // Restart with carryIn=1 on top of a stale carry_q=1 and zero operands.
    drive(0, 0, 1, 1, 1, 1);
    #1;
    n_total++;
    if ({bus.carryOut, bus.result} !== 2'b01)
      $display("FAIL restart_comb: got {carryOut,result}=%b want 01", {bus.carryOut, bus.result});
    else n_pass++;
    tick();
    n_total++;
    if (regs() !== 6'b1_0_1_0_00)
      $display("FAIL restart_reg: got regs=%b want %b", regs(), 6'b101000);
    else n_pass++;
    drive(0, 0, 0, 1, 1, 1);
    #1;
    n_total++;
    if ({bus.carryOut, bus.result} !== 2'b00)
      $display("FAIL restart_cin0: got {carryOut,result}=%b want 00", {bus.carryOut, bus.result});
    else n_pass++;
  endtask

  task automatic test_mode_toggle();
    drive(1, 1, 0, 1, 1, 1);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    #1;
    n_total++;
    if (bus.result !== 1'b1)
      $display("FAIL toggle_feedback: got result=%b want 1", bus.result);
    else n_pass++;
    bus.serial_mode = 1'b0;
    #1;
    n_total++;
    if (bus.result !== 1'b0)
      $display("FAIL toggle_ext: got result=%b want 0", bus.result);
    else n_pass++;
    tick();
    n_total++;
    if (regs() !== 6'b0_0_1_0_00)
      $display("FAIL toggle_reg: got regs=%b want %b", regs(), 6'b001000);
    else n_pass++;
  endtask

  task automatic test_abort();
    drive(1, 1, 0, 1, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (regs() !== 6'b0)
      $display("FAIL abort_reset: got regs=%b want %b", regs(), 6'b0);
    else n_pass++;
    #2;
    rst = 1'b0;
    drive(1, 0, 0, 1, 1, 0);
    #1;
    n_total++;
    if ({bus.carryOut, bus.result} !== 2'b01)
      $display("FAIL abort_carry: got {carryOut,result}=%b want 01", {bus.carryOut, bus.result});
    else n_pass++;
  endtask

  initial begin
    test_comb();
    clk = 1'b0;
    clk_run = 1'b1;
    #2;
    test_reset();
    test_registered();
    test_serial_add();
    test_serial_overflow();
    test_mode_toggle();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bit_adder.md
Name: bit_adder

Overview:
- One-bit full adder with a purely combinational sum/carry path, used as the carry-chain cell of the processor ALU.
- Adds an optional clocked wrapper: a registered copy of the result and a bit-serial accumulation mode that feeds the stored carry back into the cell.
- The serial mode adds WIDTH-bit operands LSB-first, one bit per clock.

Parameters:
- WIDTH, 32, operand length in bits for serial mode; sets the bit_count range and the last-bit detection.
- CNT_W, $clog2(WIDTH), width of bit_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- OPA  input  1  operand A bit.
- OPB  input  1  operand B bit.
- carryIn  input  1  carry into the cell; used directly when serial_mode=0.
- en  input  1  enable for the clocked stage.
- serial_mode  input  1  1 selects the registered carry as the cell's carry input.
- start  input  1  begins a new serial addition: carry input forced to carryIn and bit_count cleared on this bit.
- result  output  1  combinational sum bit.
- carryOut  output  1  combinational carry-out bit.
- result_q  output  1  registered sum bit.
- carry_q  output  1  registered carry; this is the serial feedback carry.
- valid_q  output  1  registered strobe: result_q/carry_q hold a new bit.
- bit_count  output  CNT_W  index of the last registered serial bit.
- last_q  output  1  registered strobe: the WIDTH-th serial bit completed.

Behaviour:
- Effective carry input cin_eff = (serial_mode & ~start) ? carry_q : carryIn.
- result = OPA ^ OPB ^ cin_eff.
- carryOut = (OPA & OPB) | (cin_eff & (OPA ^ OPB)).
- Combinational path has zero latency and does not depend on clk, rst or en in non-serial mode. It must produce correct values even if clk and rst are never driven.
- Reset (asynchronous, active-high): result_q=0, carry_q=0, valid_q=0, last_q=0, bit_count=0. Reset asserted mid-serial-operation aborts it immediately.
- Rising edge with en=1: result_q<=result, carry_q<=carryOut, valid_q<=1 (one-cycle latency).
  - If start=1 or serial_mode=0: bit_count<=0.
  - Otherwise: bit_count<=bit_count+1, wrapping to 0 after WIDTH-1.
  - last_q<=1 when serial_mode=1 and the bit being registered has index WIDTH-1; otherwise last_q<=0.
- Rising edge with en=0: result_q, carry_q and bit_count hold; valid_q<=0 and last_q<=0.
- start and serial_mode both 1 on the same cycle: start wins; carryIn is used and the bit is index 0.
- Toggling serial_mode mid-operation: carry source switches on the next combinational evaluation; bit_count restarts at 0 while serial_mode=0.

Decomposition:
- Shared package alu_pkg: WIDTH default constant.
- Sub-module full_adder_cell: pure combinational sum/carry. bit_adder instantiates it and adds the carry mux, registers and counter.

Test Plan:
- Exhaustive combinational check, serial_mode=0, clk/rst left undriven: all 8 combinations of OPA, OPB, carryIn. Required: 1+0+0 -> result=1, carryOut=0; 1+0+1 -> 0,1; 1+1+0 -> 0,1; 1+1+1 -> 1,1; 0+0+0 -> 0,0.
- Reset: assert rst between clock edges -> result_q=0, carry_q=0, valid_q=0, last_q=0, bit_count=0 immediately, without a clock edge.
- Registered path: en=1, OPA=1, OPB=1, carryIn=1, one edge -> result_q=1, carry_q=1, valid_q=1. Then en=0 for one edge -> outputs hold, valid_q=0.
- Serial add with WIDTH=4: 0b0111+0b0001, start on bit 0, carryIn=0 -> sum bits 0,0,0,1; carry_q=0 after bit 3; last_q=1 on bit 3 only; bit_count 0..3.
- Serial overflow with WIDTH=4: 0b1111+0b0001 -> sum 0b0000 and carry_q=1 after last bit. A new start with carryIn=1 ignores the stale carry_q.
